// File: rtl/console_pkg.sv
// console_pkg: definitions shared by the console receive path.
//   rx_state_t      receive FSM state encoding
//   CONSOLE_*       reset divider, smallest usable divider, empty-read sentinel
//   clamp_div()     raises a programmed divider to the smallest usable value
package console_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  localparam logic [31:0] CONSOLE_DEFAULT_DIV = 32'd53333;
  localparam logic [31:0] CONSOLE_MIN_DIV     = 32'd4;
  localparam logic [31:0] CONSOLE_EMPTY       = 32'hFFFF_FFFF;

  function automatic logic [31:0] clamp_div(input logic [31:0] div, input logic [31:0] min_div);
    logic [31:0] res;
    if (div < min_div) begin
      res = min_div;
    end else begin
      res = div;
    end
    return res;
  endfunction

endpackage

// File: rtl/console_byte_fifo.sv
// console_byte_fifo: circular byte buffer.
//   clk, resetn   clock, synchronous active-low reset
//   push, din     write request and byte
//   pop           read request (ignored when empty)
//   head          byte at the read pointer
//   empty, full   fill status
//   dropped       a push was refused because the buffer was full and not popping
module console_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       dropped
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == CNT_W'(0));
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full buffer still accepts a push alongside it.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    dropped = push & ~do_push;
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/console_rx_fifo.sv
// console_rx_fifo: 8N1 serial receiver with a small receive buffer.
//   clk, resetn     clock, synchronous active-low reset
//   ser_rx          asynchronous serial line, idle high
//   reg_div_we/di   byte-lane writes to the clocks-per-bit divider
//   reg_div_do      divider register readback
//   reg_dat_re      pop strobe for the buffered head byte
//   reg_dat_do      {24'h0, head} or all-ones when nothing is buffered
//   rx_valid        buffer non-empty
//   rx_overrun      sticky: a received byte was dropped (buffer full)
//   rx_frame_err    sticky: a stop bit was sampled low
module console_rx_fifo
  import console_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] DEFAULT_DIV = CONSOLE_DEFAULT_DIV,
  parameter logic [31:0] MIN_DIV     = CONSOLE_MIN_DIV
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_re,
  output logic [31:0] reg_dat_do,
  output logic        rx_valid,
  output logic        rx_overrun,
  output logic        rx_frame_err
);

  logic        rx_meta;
  logic        rx_s;
  logic        rx_prev;
  logic [31:0] div_reg;
  logic [31:0] eff_div;
  logic [31:0] bit_div;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  rx_state_t   state;
  logic        tick;
  logic        push;
  logic [7:0]  head;
  logic        empty;
  logic        full;
  logic        dropped;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Divider register with independent byte-lane writes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_reg <= DEFAULT_DIV;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reg_div_we[i]) div_reg[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
    end
  end

  // Counter expiry and the push request raised by a good stop bit on the sampling edge.
  always_comb begin
    eff_div = clamp_div(div_reg, MIN_DIV);
    tick    = (cnt <= 32'd1);
    push    = (state == RX_STOP) & tick & rx_s;
  end

  // Receive FSM: the counter reaches 1 on each sampling edge, half a bit in for the start bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= RX_IDLE;
      bit_div      <= DEFAULT_DIV;
      cnt          <= 32'd0;
      bit_idx      <= 3'd0;
      shreg        <= 8'd0;
      rx_frame_err <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s && rx_prev) begin
            state   <= RX_START;
            bit_div <= eff_div;
            cnt     <= eff_div >> 1;
          end
        end
        RX_START: begin
          if (tick) begin
            if (!rx_s) begin
              state   <= RX_DATA;
              bit_idx <= 3'd0;
              cnt     <= bit_div;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        RX_DATA: begin
          if (tick) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= bit_div;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_s) begin
              state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= RX_BREAK;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        RX_BREAK: begin
          // A line held low must rise before a new start bit can be recognised.
          if (rx_s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_overrun <= 1'b0;
    end else if (dropped) begin
      rx_overrun <= 1'b1;
    end
  end

  console_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .din     (shreg),
    .pop     (reg_dat_re),
    .head    (head),
    .empty   (empty),
    .full    (full),
    .dropped (dropped)
  );

  assign reg_div_do = div_reg;
  assign rx_valid   = ~empty;
  assign reg_dat_do = empty ? CONSOLE_EMPTY : {24'h0, head};

endmodule

// File: tb/tb_console_rx_fifo.sv
// tb_console_rx_fifo: directed bench for console_rx_fifo.
// Inputs change on the falling clock edge; outputs are sampled on the falling edge.
module tb_console_rx_fifo;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ser_rx = 1'b1;
  logic [3:0]  reg_div_we = 4'd0;
  logic [31:0] reg_div_di = 32'd0;
  logic [31:0] reg_div_do;
  logic        reg_dat_re = 1'b0;
  logic [31:0] reg_dat_do;
  logic        rx_valid;
  logic        rx_overrun;
  logic        rx_frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int bit_clks = 16;

  console_rx_fifo dut (
    .clk          (clk),
    .resetn       (resetn),
    .ser_rx       (ser_rx),
    .reg_div_we   (reg_div_we),
    .reg_div_di   (reg_div_di),
    .reg_div_do   (reg_div_do),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_do   (reg_dat_do),
    .rx_valid     (rx_valid),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ser_rx = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_div(input logic [3:0] we, input logic [31:0] di);
    reg_div_we = we;
    reg_div_di = di;
    @(negedge clk);
    reg_div_we = 4'd0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    chk(tag, reg_dat_do, exp);
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
  endtask

  // mode 0: plain; 1: check push latency (buffer empty beforehand); 2: pop on the push edge.
  // With the start bit driven just before edge e0, the stop bit is sampled on edge
  // e(2 + bit_clks/2 + 9*bit_clks): iteration (3 + bit_clks/2) of the stop-bit loop.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int mode);
    logic bitv;
    int   i_push;
    i_push = 3 + bit_clks / 2;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      bitv = 1'b0;
      else if (k == 9) bitv = stop_bit;
      else             bitv = b[k-1];
      ser_rx = bitv;
      for (int i = 1; i <= bit_clks; i++) begin
        @(negedge clk);
        if (k == 9 && mode == 1 && i == i_push - 1) chk("lat_before", {31'd0, rx_valid}, 32'd0);
        if (k == 9 && mode == 1 && i == i_push) begin
          chk("lat_valid", {31'd0, rx_valid}, 32'd1);
          chk("lat_data", reg_dat_do, {24'd0, b});
        end
        if (k == 9 && mode == 2 && i == i_push - 1) reg_dat_re = 1'b1;
        if (k == 9 && mode == 2 && i == i_push)     reg_dat_re = 1'b0;
      end
    end
  endtask

  initial begin
    do_reset();
    chk("rst_div", reg_div_do, 32'd53333);
    chk("rst_dat", reg_dat_do, 32'hFFFF_FFFF);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
    chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);

    // Single frame with push-latency check.
    write_div(4'b1111, 32'd16);
    chk("div16", reg_div_do, 32'd16);
    bit_clks = 16;
    send_frame(8'h55, 1'b1, 1);
    pop_check("t1_head", 32'h0000_0055);
    chk("t1_empty", reg_dat_do, 32'hFFFF_FFFF);
    chk("t1_valid", {31'd0, rx_valid}, 32'd0);

    // Overrun: five frames into four slots.
    for (int n = 1; n <= 5; n++) begin
      if (n == 5) chk("t2_no_ovr_yet", {31'd0, rx_overrun}, 32'd0);
      send_frame(8'(n), 1'b1, 0);
    end
    chk("t2_ovr", {31'd0, rx_overrun}, 32'd1);
    for (int n = 1; n <= 4; n++) pop_check("t2_drain", 32'(n));
    chk("t2_empty", reg_dat_do, 32'hFFFF_FFFF);

    // Push and pop on the same edge with a full buffer.
    do_reset();
    write_div(4'b1111, 32'd16);
    send_frame(8'h10, 1'b1, 0);
    send_frame(8'h20, 1'b1, 0);
    send_frame(8'h30, 1'b1, 0);
    send_frame(8'h40, 1'b1, 0);
    chk("t3_head_full", reg_dat_do, 32'h0000_0010);
    send_frame(8'hA5, 1'b1, 2);
    chk("t3_no_ovr", {31'd0, rx_overrun}, 32'd0);
    pop_check("t3_d0", 32'h0000_0020);
    pop_check("t3_d1", 32'h0000_0030);
    pop_check("t3_d2", 32'h0000_0040);
    pop_check("t3_d3", 32'h0000_00A5);
    chk("t3_empty", reg_dat_do, 32'hFFFF_FFFF);

    // False start: a 4-cycle low pulse.
    ser_rx = 1'b0;
    repeat (4) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("t4_no_push", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h3C, 1'b1, 0);
    pop_check("t4_3c", 32'h0000_003C);

    // Framing error followed by a held-low line.
    send_frame(8'h7E, 1'b0, 0);
    repeat (100) @(negedge clk);
    chk("t5_ferr", {31'd0, rx_frame_err}, 32'd1);
    chk("t5_valid_low", {31'd0, rx_valid}, 32'd0);
    ser_rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_valid_rise", {31'd0, rx_valid}, 32'd0);
    send_frame(8'h11, 1'b1, 0);
    pop_check("t5_11", 32'h0000_0011);

    // Divider below the minimum is clamped to 4 clocks per bit.
    write_div(4'b1111, 32'd2);
    chk("t6_div2", reg_div_do, 32'd2);
    bit_clks = 4;
    send_frame(8'h9A, 1'b1, 0);
    repeat (4) @(negedge clk);
    pop_check("t6_9a", 32'h0000_009A);
    write_div(4'b0010, 32'h0000_AB00);
    chk("t6_lane", reg_div_do, 32'h0000_AB02);
    write_div(4'b1111, 32'd4);

    // Reset in the middle of a frame.
    ser_rx = 1'b0;
    repeat (10) @(negedge clk);
    do_reset();
    repeat (60) @(negedge clk);
    chk("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("t6_rst_dat", reg_dat_do, 32'hFFFF_FFFF);
    chk("t6_rst_div", reg_div_do, 32'd53333);
    chk("t6_rst_ovr", {31'd0, rx_overrun}, 32'd0);
    chk("t6_rst_ferr", {31'd0, rx_frame_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
